// File: rtl/tern_matvec_stream.sv
// rtl/tern_matvec_stream.sv - streaming ternary-weight matrix-vector product, one row result per pass row.
// Optional output saturation is enabled by defining TERN_OUT_SAT_EN.
module tern_matvec_stream #(
    parameter int ACT_W  = 8,
    parameter int N_COLS = 4096,
    parameter int N_ROWS = 4096,
    parameter int LANES  = 16,
    parameter int OUT_W  = 20
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       act_we,
    input  logic [$clog2(N_COLS)-1:0]  act_addr,
    input  logic [ACT_W-1:0]           act_data,
    input  logic                       start,
    input  logic                       w_valid,
    output logic                       w_ready,
    input  logic [2*LANES-1:0]         w_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OUT_W-1:0]           out_data,
    output logic [$clog2(N_ROWS)-1:0]  out_row,
    output logic                       busy,
    output logic                       done
);
    localparam int AW    = $clog2(N_COLS);
    localparam int RW    = $clog2(N_ROWS);
    localparam int ACC_W = ACT_W + AW + 1;
    localparam logic [AW-1:0] COL_STEP = AW'(LANES);
    localparam logic [AW-1:0] COL_LAST = AW'(N_COLS - LANES);
    localparam logic [RW-1:0] ROW_LAST = RW'(N_ROWS - 1);

    typedef enum logic [1:0] {IDLE, ACC, EMIT} state_t;

    state_t                   state;
    state_t                   next_state;
    logic signed [ACT_W-1:0]  act_mem [N_COLS];
    logic [AW-1:0]            col;
    logic [RW-1:0]            row;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  beat_sum;
    logic                     beat_take;
    logic                     out_take;

    function automatic logic signed [ACC_W-1:0] sx(input logic signed [ACT_W-1:0] a);
        return {{(ACC_W-ACT_W){a[ACT_W-1]}}, a};
    endfunction

    assign w_ready   = (state == ACC);
    assign out_valid = (state == EMIT);
    assign busy      = (state != IDLE);
    assign beat_take = w_ready && w_valid;
    assign out_take  = out_valid && out_ready;
    assign out_row   = row;

    // col tracks beat*LANES so each lane reads its activation directly.
    always_comb begin
        beat_sum = '0;
        for (int k = 0; k < LANES; k++) begin
            case (w_data[2*k +: 2])
                2'b01:   beat_sum = beat_sum + sx(act_mem[col + AW'(k)]);
                2'b11:   beat_sum = beat_sum - sx(act_mem[col + AW'(k)]);
                default: beat_sum = beat_sum;
            endcase
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = ACC;
            ACC:     if (beat_take && col == COL_LAST) next_state = EMIT;
            EMIT:    if (out_take) next_state = (row == ROW_LAST) ? IDLE : ACC;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc  <= '0;
            col  <= '0;
            row  <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    acc <= '0;
                    col <= '0;
                    row <= '0;
                end
                ACC: if (beat_take) begin
                    acc <= acc + beat_sum;
                    col <= (col == COL_LAST) ? '0 : col + COL_STEP;
                end
                EMIT: if (out_take) begin
                    if (row == ROW_LAST) begin
                        done <= 1'b1;
                    end else begin
                        row <= row + 1'b1;
                        acc <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Activation contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && act_we) act_mem[act_addr] <= act_data;
    end

`ifdef TERN_OUT_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    always_comb begin
        if (acc > SAT_MAX)      out_data = SAT_MAX[OUT_W-1:0];
        else if (acc < SAT_MIN) out_data = SAT_MIN[OUT_W-1:0];
        else                    out_data = acc[OUT_W-1:0];
    end
`else
    assign out_data = acc[OUT_W-1:0];
`endif

endmodule

// File: tb/tb_tern_matvec_stream.sv
// tb/tb_tern_matvec_stream.sv - directed bench for tern_matvec_stream (N_COLS=8, LANES=4, N_ROWS=2, OUT_W=8).
module tb_tern_matvec_stream;
    logic        clk = 1'b0;
    logic        rst;
    logic        act_we;
    logic [2:0]  act_addr;
    logic [7:0]  act_data;
    logic        start;
    logic        w_valid;
    logic        w_ready;
    logic [7:0]  w_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [0:0]  out_row;
    logic        busy;
    logic        done;

    int vectors = 0;
    int miscompares = 0;

    tern_matvec_stream #(
        .ACT_W(8), .N_COLS(8), .N_ROWS(2), .LANES(4), .OUT_W(8)
    ) dut (
        .clk(clk), .rst(rst), .act_we(act_we), .act_addr(act_addr), .act_data(act_data),
        .start(start), .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_row(out_row), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, 32'(out_valid), 0);
        check({tag, "_out_data"}, 32'(out_data), 0);
        check({tag, "_out_row"}, 32'(out_row), 0);
        check({tag, "_w_ready"}, 32'(w_ready), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
    endtask

    task automatic load_act(input logic [7:0] base, input logic [7:0] step);
        for (int i = 0; i < 8; i++) begin
            act_we = 1'b1;
            act_addr = 3'(i);
            act_data = base + step * 8'(i);
            @(negedge clk);
        end
        act_we = 1'b0;
    endtask

    task automatic do_start;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_beat(input logic [7:0] w);
        int n;
        w_valid = 1'b1;
        w_data = w;
        n = 0;
        while (!w_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!w_ready) check("w_ready_timeout", 0, 1);
        @(negedge clk);
        w_valid = 1'b0;
    endtask

    task automatic take_row(input string tag, input int exp_data, input int exp_row);
        int n;
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, 32'(out_valid), 1);
        check({tag, "_data"}, 32'($signed(out_data)), exp_data);
        check({tag, "_row"}, 32'(out_row), exp_row);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    logic [7:0] held_data;

    initial begin
        rst = 1'b1; act_we = 1'b0; act_addr = '0; act_data = '0; start = 1'b0;
        w_valid = 1'b0; w_data = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // act = 1..8; row 0 all +1, row 1 all -1
        load_act(8'd1, 8'd1);
        do_start();
        check("busy_after_start", 32'(busy), 1);
        send_beat(8'h55);
        repeat (3) @(negedge clk);
        send_beat(8'h55);
        check("emit_latency", 32'(out_valid), 1);
        check("emit_w_ready", 32'(w_ready), 0);
        take_row("r0_plus", 36, 0);
        send_beat(8'hFF);
        send_beat(8'hFF);
        take_row("r1_minus", -36, 1);
        check("done_pulse", 32'(done), 1);
        @(negedge clk);
        check("done_low", 32'(done), 0);
        check("idle_busy", 32'(busy), 0);

        // mixed codes with act = 5 cancel; stall EMIT with a beat on offer
        load_act(8'd5, 8'd0);
        do_start();
        send_beat(8'h8D);
        send_beat(8'h8D);
        take_row("mixed_zero", 0, 0);
        send_beat(8'h55);
        send_beat(8'h55);
        held_data = out_data;
        w_valid = 1'b1;
        w_data = 8'h55;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_valid", 32'(out_valid), 1);
            check("stall_data", 32'(out_data), 32'(held_data));
            check("stall_row", 32'(out_row), 1);
            check("stall_w_ready", 32'(w_ready), 0);
        end
        w_valid = 1'b0;
        take_row("stall_row1", 40, 1);
        @(negedge clk);

        // act = 127: +/-1016 overflows OUT_W=8; act_we/start ignored while busy
        load_act(8'd127, 8'd0);
        do_start();
        send_beat(8'h55);
        act_we = 1'b1; act_addr = 3'd0; act_data = 8'd99; start = 1'b1;
        @(negedge clk);
        act_we = 1'b0; start = 1'b0;
        send_beat(8'h55);
`ifdef TERN_OUT_SAT_EN
        take_row("wide_pos", 127, 0);
`else
        take_row("wide_pos", -8, 0);
`endif
        send_beat(8'hFF);
        send_beat(8'hFF);
`ifdef TERN_OUT_SAT_EN
        take_row("wide_neg", -128, 1);
`else
        take_row("wide_neg", 8, 1);
`endif
        @(negedge clk);

        // reset in the middle of row 1
        load_act(8'd1, 8'd1);
        do_start();
        send_beat(8'h55);
        send_beat(8'h55);
        take_row("pre_rst_r0", 36, 0);
        send_beat(8'hFF);
        w_valid = 1'b1;
        w_data = 8'hFF;
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid_rst");
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_w_ready", 32'(w_ready), 0);
        check("post_rst_busy", 32'(busy), 0);
        w_valid = 1'b0;
        load_act(8'd1, 8'd1);
        do_start();
        send_beat(8'h55);
        send_beat(8'h55);
        take_row("restart_r0", 36, 0);
        send_beat(8'hFF);
        send_beat(8'hFF);
        take_row("restart_r1", -36, 1);
        check("restart_done", 32'(done), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
